// File: rtl/lsu_mem_access.sv
// LoongArch32 load/store unit: alignment check, single-outstanding dcache
// request, and sign/zero extension of returned load data for write-back.
module lsu_mem_access #(
  parameter bit ALE_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_aluop,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_pc,
  output logic        dcache_req_valid,
  input  logic        dcache_req_ready,
  output logic [31:0] dcache_addr,
  output logic        dcache_we,
  output logic [3:0]  dcache_wstrb,
  output logic [31:0] dcache_wdata,
  input  logic        dcache_resp_valid,
  input  logic [31:0] dcache_rdata,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [6:0]  exc_cause,
  output logic [31:0] exc_badv,
  output logic [31:0] exc_pc
);
  localparam logic [7:0] ALU_LDB  = 8'h30;
  localparam logic [7:0] ALU_LDH  = 8'h31;
  localparam logic [7:0] ALU_LDW  = 8'h32;
  localparam logic [7:0] ALU_LDBU = 8'h33;
  localparam logic [7:0] ALU_LDHU = 8'h34;
  localparam logic [7:0] ALU_STB  = 8'h38;
  localparam logic [7:0] ALU_STH  = 8'h39;
  localparam logic [7:0] ALU_STW  = 8'h3A;
  localparam logic [6:0] EXCEPTION_ALE = 7'h09;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  function automatic logic is_load(input logic [7:0] op);
    return (op == ALU_LDB) || (op == ALU_LDH) || (op == ALU_LDW) ||
           (op == ALU_LDBU) || (op == ALU_LDHU);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == ALU_STB) || (op == ALU_STH) || (op == ALU_STW);
  endfunction

  function automatic logic is_half(input logic [7:0] op);
    return (op == ALU_LDH) || (op == ALU_LDHU) || (op == ALU_STH);
  endfunction

  function automatic logic is_word(input logic [7:0] op);
    return (op == ALU_LDW) || (op == ALU_STW);
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, pc_q, pc_d;
  logic [4:0]  rd_q, rd_d;
  logic        wb_valid_q, wb_valid_d, wb_en_q, wb_en_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        exc_valid_q, exc_valid_d;
  logic [6:0]  exc_cause_q, exc_cause_d;
  logic [31:0] exc_badv_q, exc_badv_d, exc_pc_q, exc_pc_d;

  logic [1:0]  off_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        misaligned;

  assign off_q      = addr_q[1:0];
  assign misaligned = ALE_CHECK &&
                      ((is_half(req_aluop) && req_addr[0]) ||
                       (is_word(req_aluop) && (req_addr[1:0] != 2'b00)));

  always_comb begin
    ld_byte = dcache_rdata[{off_q, 3'b000} +: 8];
    ld_half = dcache_rdata[{off_q[1], 4'b0000} +: 16];
    case (op_q)
      ALU_LDB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      ALU_LDBU: ld_data = {24'h0, ld_byte};
      ALU_LDH:  ld_data = {{16{ld_half[15]}}, ld_half};
      ALU_LDHU: ld_data = {16'h0, ld_half};
      default:  ld_data = dcache_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    pc_d        = pc_q;
    wb_valid_d  = 1'b0;
    wb_en_d     = 1'b0;
    wb_addr_d   = '0;
    wb_data_d   = '0;
    exc_valid_d = 1'b0;
    exc_cause_d = '0;
    exc_badv_d  = '0;
    exc_pc_d    = '0;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          op_d    = req_aluop;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rd_d    = req_rd;
          pc_d    = req_pc;
          if (misaligned) begin
            exc_valid_d = 1'b1;
            exc_cause_d = EXCEPTION_ALE;
            exc_badv_d  = req_addr;
            exc_pc_d    = req_pc;
          end else if (!is_load(req_aluop) && !is_store(req_aluop)) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = req_rd;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // Once the handshake fires the access is committed even under flush;
        // a flushed load still has to swallow its response in DRAIN.
        if (dcache_req_ready) begin
          if (is_store(op_q)) begin
            state_d    = IDLE;
            wb_valid_d = !flush;
            wb_addr_d  = rd_q;
          end else begin
            state_d = flush ? DRAIN : WAIT;
          end
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (dcache_resp_valid) begin
          state_d = IDLE;
          if (!flush) begin
            wb_valid_d = 1'b1;
            wb_en_d    = (rd_q != 5'd0);
            wb_addr_d  = rd_q;
            wb_data_d  = ld_data;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dcache_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      pc_q        <= '0;
      wb_valid_q  <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      exc_badv_q  <= '0;
      exc_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      pc_q        <= pc_d;
      wb_valid_q  <= wb_valid_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
      exc_badv_q  <= exc_badv_d;
      exc_pc_q    <= exc_pc_d;
    end
  end

  always_comb begin
    req_ready        = (state_q == IDLE);
    dcache_req_valid = (state_q == REQ);
    dcache_addr      = '0;
    dcache_we        = 1'b0;
    dcache_wstrb     = '0;
    dcache_wdata     = '0;
    if (state_q == REQ) begin
      dcache_addr = {addr_q[31:2], 2'b00};
      dcache_we   = is_store(op_q);
      case (op_q)
        ALU_STB: begin
          dcache_wstrb = 4'b0001 << off_q;
          dcache_wdata = {4{wdata_q[7:0]}};
        end
        ALU_STH: begin
          dcache_wstrb = 4'b0011 << off_q;
          dcache_wdata = {2{wdata_q[15:0]}};
        end
        ALU_STW: begin
          dcache_wstrb = 4'b1111;
          dcache_wdata = wdata_q;
        end
        default: ;
      endcase
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign exc_valid = exc_valid_q;
  assign exc_cause = exc_cause_q;
  assign exc_badv  = exc_badv_q;
  assign exc_pc    = exc_pc_q;
endmodule

// File: tb/tb_lsu_mem_access.sv
// Bench for lsu_mem_access: directed scenarios plus randomized operations
// checked against a byte/halfword arithmetic reference model.
`timescale 1ns/1ps
module tb_lsu_mem_access;
  localparam logic [7:0] ALU_LDB  = 8'h30;
  localparam logic [7:0] ALU_LDH  = 8'h31;
  localparam logic [7:0] ALU_LDW  = 8'h32;
  localparam logic [7:0] ALU_LDBU = 8'h33;
  localparam logic [7:0] ALU_LDHU = 8'h34;
  localparam logic [7:0] ALU_STB  = 8'h38;
  localparam logic [7:0] ALU_STH  = 8'h39;
  localparam logic [7:0] ALU_STW  = 8'h3A;
  localparam logic [6:0] EXC_ALE  = 7'h09;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, req_valid, req_ready;
  logic [7:0]  req_aluop;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic [4:0]  req_rd;
  logic        dcache_req_valid, dcache_req_ready, dcache_we, dcache_resp_valid;
  logic [31:0] dcache_addr, dcache_wdata, dcache_rdata;
  logic [3:0]  dcache_wstrb;
  logic        wb_valid, wb_en, exc_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, exc_badv, exc_pc;
  logic [6:0]  exc_cause;

  logic        req_valid1, flush1, dcache_req_ready1;
  logic        req_ready1, dcache_req_valid1, dcache_we1, wb_valid1, wb_en1, exc_valid1;
  logic [31:0] dcache_addr1, dcache_wdata1, wb_data1, exc_badv1, exc_pc1;
  logic [3:0]  dcache_wstrb1;
  logic [4:0]  wb_addr1;
  logic [6:0]  exc_cause1;

  lsu_mem_access #(.ALE_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .req_pc(req_pc), .dcache_req_valid(dcache_req_valid), .dcache_req_ready(dcache_req_ready),
    .dcache_addr(dcache_addr), .dcache_we(dcache_we), .dcache_wstrb(dcache_wstrb),
    .dcache_wdata(dcache_wdata), .dcache_resp_valid(dcache_resp_valid), .dcache_rdata(dcache_rdata),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_badv(exc_badv), .exc_pc(exc_pc)
  );

  lsu_mem_access #(.ALE_CHECK(1'b0)) dut_noale (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_aluop(req_aluop), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .req_pc(req_pc), .dcache_req_valid(dcache_req_valid1), .dcache_req_ready(dcache_req_ready1),
    .dcache_addr(dcache_addr1), .dcache_we(dcache_we1), .dcache_wstrb(dcache_wstrb1),
    .dcache_wdata(dcache_wdata1), .dcache_resp_valid(1'b0), .dcache_rdata(dcache_rdata),
    .wb_valid(wb_valid1), .wb_en(wb_en1), .wb_addr(wb_addr1), .wb_data(wb_data1),
    .exc_valid(exc_valid1), .exc_cause(exc_cause1), .exc_badv(exc_badv1), .exc_pc(exc_pc1)
  );

  logic [180:0] all_out;
  assign all_out = {dcache_req_valid, dcache_addr, dcache_we, dcache_wstrb, dcache_wdata,
                    wb_valid, wb_en, wb_addr, wb_data, exc_valid, exc_cause, exc_badv, exc_pc};

  int tests = 0;
  int fails = 0;

  // Observations captured by run_op
  bit          r_got_req, r_stable, r_wb, r_exc, r_rdy, r_after;
  int unsigned r_req_cnt, r_wb_cyc, r_exc_cyc;
  logic [31:0] r_addr, r_wdata, r_wb_data, r_badv, r_pc;
  logic [3:0]  r_strb;
  logic        r_we, r_wb_en;
  logic [4:0]  r_wb_addr;
  logic [6:0]  r_cause;

  function automatic int unsigned op_size(input logic [7:0] op);
    if (op == ALU_LDB || op == ALU_LDBU || op == ALU_STB) return 1;
    if (op == ALU_LDH || op == ALU_LDHU || op == ALU_STH) return 2;
    if (op == ALU_LDW || op == ALU_STW) return 4;
    return 0;
  endfunction

  function automatic bit op_is_store(input logic [7:0] op);
    return op == ALU_STB || op == ALU_STH || op == ALU_STW;
  endfunction

  function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] a,
                                             input logic [31:0] d);
    int unsigned o;
    logic [31:0] b, h;
    o = a % 4;
    b = (d >> (8 * o)) & 32'hFF;
    h = (d >> (16 * (o / 2))) & 32'hFFFF;
    if (op == ALU_LDB)  return b + ((b >= 128) ? 32'hFFFFFF00 : 32'h0);
    if (op == ALU_LDBU) return b;
    if (op == ALU_LDH)  return h + ((h >= 32768) ? 32'hFFFF0000 : 32'h0);
    if (op == ALU_LDHU) return h;
    return d;
  endfunction

  function automatic logic [3:0] model_strb(input logic [7:0] op, input logic [31:0] a);
    int unsigned o;
    o = a % 4;
    if (op == ALU_STB) return 4'((1 << o) % 16);
    if (op == ALU_STH) return 4'((3 << o) % 16);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [7:0] op, input logic [31:0] d);
    if (op == ALU_STB) return (d % 256) * 32'h01010101;
    if (op == ALU_STH) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input logic [31:0] pc, input int unsigned rdly,
                        input int unsigned sdly, input logic [31:0] rdata);
    int unsigned nreq, after;
    bit hs, sent, done;
    nreq = 0; after = 0; hs = 0; sent = 0; done = 0;
    r_got_req = 0; r_stable = 1; r_wb = 0; r_exc = 0; r_rdy = 0; r_after = 0;
    r_req_cnt = 0; r_wb_cyc = 0; r_exc_cyc = 0;
    @(negedge clk);
    req_valid = 1'b1; req_aluop = op; req_addr = addr; req_wdata = wd; req_rd = rd; req_pc = pc;
    @(posedge clk); #1 req_valid = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      dcache_req_ready = 1'b0; dcache_resp_valid = 1'b0; dcache_rdata = ~rdata;
      if (wb_valid) begin
        r_wb = 1; r_wb_cyc = c; r_wb_en = wb_en; r_wb_addr = wb_addr; r_wb_data = wb_data;
        r_rdy = req_ready; done = 1;
      end
      if (exc_valid) begin
        r_exc = 1; r_exc_cyc = c; r_cause = exc_cause; r_badv = exc_badv; r_pc = exc_pc; done = 1;
      end
      if (dcache_req_valid) begin
        if (nreq == 0) begin
          r_addr = dcache_addr; r_we = dcache_we; r_strb = dcache_wstrb; r_wdata = dcache_wdata;
        end else if ({r_addr, r_we, r_strb, r_wdata} !== {dcache_addr, dcache_we, dcache_wstrb, dcache_wdata}) begin
          r_stable = 0;
        end
        r_got_req = 1;
        if (nreq >= rdly) begin dcache_req_ready = 1'b1; hs = 1; end
        nreq++;
      end else if (hs && !sent && !done) begin
        if (after == sdly) begin dcache_resp_valid = 1'b1; dcache_rdata = rdata; sent = 1; end
        after++;
      end
    end
    r_req_cnt = nreq;
    @(negedge clk);
    dcache_req_ready = 1'b0; dcache_resp_valid = 1'b0;
    r_after = wb_valid | exc_valid | dcache_req_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (all_out !== '0) begin fails++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_word();
    run_op(ALU_LDW, 32'h1000, 32'h0, 5'd5, 32'h1C000000, 0, 0, 32'hDEADBEEF);
    tests++; if (r_got_req !== 1'b1 || r_addr !== 32'h1000 || r_we !== 1'b0 || r_strb !== 4'h0) begin
      fails++; $display("FAIL ldw_req: got req=%b addr=%h we=%b strb=%b expected 1 00001000 0 0000", r_got_req, r_addr, r_we, r_strb); end
    tests++; if (r_wb !== 1'b1 || r_wb_cyc != 3) begin
      fails++; $display("FAIL ldw_latency: got wb=%b cycle=%0d expected 1 3", r_wb, r_wb_cyc); end
    tests++; if ({r_wb_en, r_wb_addr, r_wb_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      fails++; $display("FAIL ldw_wb: got en=%b rd=%0d data=%h expected 1 5 deadbeef", r_wb_en, r_wb_addr, r_wb_data); end
    tests++; if (r_after !== 1'b0) begin fails++; $display("FAIL ldw_pulse: got %b expected 0", r_after); end
  endtask

  task automatic test_load_ext();
    logic [7:0]  ops [5];
    logic [31:0] adr [5];
    logic [4:0]  rds [5];
    logic [31:0] exp [5];
    logic        ens [5];
    ops = '{ALU_LDB, ALU_LDBU, ALU_LDH, ALU_LDHU, ALU_LDW};
    adr = '{32'h1003, 32'h1003, 32'h1002, 32'h1002, 32'h1000};
    rds = '{5'd7, 5'd8, 5'd9, 5'd10, 5'd0};
    exp = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h80FF1234};
    ens = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], adr[i], 32'h0, rds[i], 32'h1C000010, 0, 0, 32'h80FF1234);
      tests++; if (r_wb !== 1'b1 || r_wb_en !== ens[i]) begin
        fails++; $display("FAIL ldext_en[%0d]: got wb=%b en=%b expected 1 %b", i, r_wb, r_wb_en, ens[i]); end
      if (ens[i]) begin
        tests++; if (r_wb_data !== exp[i]) begin
          fails++; $display("FAIL ldext_data[%0d]: got %h expected %h", i, r_wb_data, exp[i]); end
      end
    end
  endtask

  task automatic test_store_stall();
    run_op(ALU_STH, 32'h2002, 32'h1234ABCD, 5'd3, 32'h1C000020, 4, 0, 32'h0);
    tests++; if (r_stable !== 1'b1 || r_req_cnt != 5) begin
      fails++; $display("FAIL sth_hold: got stable=%b cycles=%0d expected 1 5", r_stable, r_req_cnt); end
    tests++; if ({r_addr, r_we, r_strb, r_wdata} !== {32'h2000, 1'b1, 4'b1100, 32'hABCDABCD}) begin
      fails++; $display("FAIL sth_req: got addr=%h we=%b strb=%b data=%h expected 00002000 1 1100 abcdabcd", r_addr, r_we, r_strb, r_wdata); end
    tests++; if (r_wb !== 1'b1 || r_wb_cyc != 6 || r_wb_en !== 1'b0) begin
      fails++; $display("FAIL sth_wb: got wb=%b cycle=%0d en=%b expected 1 6 0", r_wb, r_wb_cyc, r_wb_en); end
  endtask

  task automatic test_ale();
    @(negedge clk);
    req_aluop = ALU_LDW; req_addr = 32'h1002; req_wdata = 32'h0; req_rd = 5'd6; req_pc = 32'h1C000100;
    req_valid = 1'b1; req_valid1 = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0; req_valid1 = 1'b0;
    @(negedge clk);
    tests++; if ({exc_valid, exc_cause, exc_badv, exc_pc} !== {1'b1, EXC_ALE, 32'h1002, 32'h1C000100}) begin
      fails++; $display("FAIL ale_exc: got v=%b cause=%h badv=%h pc=%h expected 1 09 00001002 1c000100", exc_valid, exc_cause, exc_badv, exc_pc); end
    tests++; if (dcache_req_valid !== 1'b0 || wb_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL ale_noreq: got req=%b wb=%b ready=%b expected 0 0 1", dcache_req_valid, wb_valid, req_ready); end
    tests++; if (dcache_req_valid1 !== 1'b1 || dcache_addr1 !== 32'h1000 || exc_valid1 !== 1'b0) begin
      fails++; $display("FAIL noale_req: got req=%b addr=%h exc=%b expected 1 00001000 0", dcache_req_valid1, dcache_addr1, exc_valid1); end
    flush1 = 1'b1;
    @(negedge clk);
    flush1 = 1'b0;
    tests++; if (exc_valid !== 1'b0 || dcache_req_valid !== 1'b0) begin
      fails++; $display("FAIL ale_pulse: got exc=%b req=%b expected 0 0", exc_valid, dcache_req_valid); end
    tests++; if (dcache_req_valid1 !== 1'b0) begin
      fails++; $display("FAIL noale_flush: got %b expected 0", dcache_req_valid1); end
  endtask

  task automatic test_flush_wait();
    bit wbseen;
    wbseen = 0;
    @(negedge clk);
    req_aluop = ALU_LDW; req_addr = 32'h1000; req_rd = 5'd4; req_pc = 32'h1C000200; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      dcache_req_ready = 1'b0; dcache_resp_valid = 1'b0; flush = 1'b0;
      if (wb_valid) wbseen = 1;
      if (c == 1) begin
        tests++; if (dcache_req_valid !== 1'b1) begin fails++; $display("FAIL fw_req: got %b expected 1", dcache_req_valid); end
        dcache_req_ready = 1'b1;
      end
      if (c == 2) flush = 1'b1;
      if (c >= 3 && c <= 5) begin
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL fw_drain_ready[%0d]: got %b expected 0", c, req_ready); end
      end
      if (c == 5) begin dcache_resp_valid = 1'b1; dcache_rdata = 32'h12345678; end
      if (c == 6) begin
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL fw_idle_ready: got %b expected 1", req_ready); end
      end
    end
    tests++; if (wbseen !== 1'b0) begin fails++; $display("FAIL fw_no_wb: got %b expected 0", wbseen); end
  endtask

  task automatic test_flush_req();
    bit wbseen;
    wbseen = 0;
    @(negedge clk);
    req_aluop = ALU_LDW; req_addr = 32'h1100; req_rd = 5'd9; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    tests++; if (dcache_req_valid !== 1'b1) begin fails++; $display("FAIL fr_req: got %b expected 1", dcache_req_valid); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests++; if (dcache_req_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL fr_drop: got req=%b ready=%b expected 0 1", dcache_req_valid, req_ready); end
    dcache_resp_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dcache_resp_valid = 1'b0;
      if (wb_valid) wbseen = 1;
    end
    tests++; if (wbseen !== 1'b0) begin fails++; $display("FAIL fr_stray_resp: got %b expected 0", wbseen); end
  endtask

  task automatic test_reset_in_req();
    @(negedge clk);
    req_aluop = ALU_STW; req_addr = 32'h4000; req_wdata = 32'h55AA55AA; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    tests++; if (dcache_req_valid !== 1'b1) begin fails++; $display("FAIL rr_req: got %b expected 1", dcache_req_valid); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (all_out !== '0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL rr_async: got out=%h ready=%b expected 0 1", all_out, req_ready); end
    @(negedge clk);
    dcache_resp_valid = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    dcache_resp_valid = 1'b0;
    tests++; if (all_out !== '0) begin fails++; $display("FAIL rr_ignore_resp: got %h expected 0", all_out); end
    run_op(ALU_STB, 32'h3001, 32'h000000AB, 5'd2, 32'h1C000300, 1, 0, 32'h0);
    tests++; if ({r_addr, r_we, r_strb, r_wdata} !== {32'h3000, 1'b1, 4'b0010, 32'hABABABAB}) begin
      fails++; $display("FAIL rr_stb: got addr=%h we=%b strb=%b data=%h expected 00003000 1 0010 abababab", r_addr, r_we, r_strb, r_wdata); end
    tests++; if (r_wb !== 1'b1 || r_wb_cyc != 3 || r_wb_en !== 1'b0) begin
      fails++; $display("FAIL rr_stb_wb: got wb=%b cycle=%0d en=%b expected 1 3 0", r_wb, r_wb_cyc, r_wb_en); end
  endtask

  task automatic test_random();
    logic [7:0]  op_tbl [9];
    logic [7:0]  op;
    logic [31:0] addr, wd, pc, rdata;
    logic [4:0]  rd;
    int unsigned rdly, sdly, sz;
    bit          mis;
    op_tbl = '{ALU_LDB, ALU_LDH, ALU_LDW, ALU_LDBU, ALU_LDHU, ALU_STB, ALU_STH, ALU_STW, 8'h00};
    for (int it = 0; it < 200; it++) begin
      op    = op_tbl[$urandom_range(0, 8)];
      addr  = $urandom;
      wd    = $urandom;
      pc    = $urandom;
      rdata = $urandom;
      rd    = 5'($urandom_range(0, 31));
      rdly  = $urandom_range(0, 3);
      sdly  = $urandom_range(0, 3);
      sz    = op_size(op);
      mis   = (sz == 2 && addr % 2 != 0) || (sz == 4 && addr % 4 != 0);
      run_op(op, addr, wd, rd, pc, rdly, sdly, rdata);
      tests++; if (r_wb == r_exc || r_after !== 1'b0) begin
        fails++; $display("FAIL rnd_done[%0d]: got wb=%b exc=%b after=%b expected exactly one pulse", it, r_wb, r_exc, r_after); end
      if (mis) begin
        tests++; if (!r_exc || r_exc_cyc != 1 || r_got_req || {r_cause, r_badv, r_pc} !== {EXC_ALE, addr, pc}) begin
          fails++; $display("FAIL rnd_ale[%0d]: got exc=%b cyc=%0d req=%b cause=%h badv=%h pc=%h expected 1 1 0 09 %h %h", it, r_exc, r_exc_cyc, r_got_req, r_cause, r_badv, r_pc, addr, pc); end
      end else if (sz == 0) begin
        tests++; if (!r_wb || r_wb_cyc != 1 || r_wb_en !== 1'b0 || r_got_req) begin
          fails++; $display("FAIL rnd_nop[%0d]: got wb=%b cyc=%0d en=%b req=%b expected 1 1 0 0", it, r_wb, r_wb_cyc, r_wb_en, r_got_req); end
      end else if (op_is_store(op)) begin
        tests++; if ({r_got_req, r_addr, r_we, r_strb, r_wdata} !== {1'b1, addr & 32'hFFFFFFFC, 1'b1, model_strb(op, addr), model_wdata(op, wd)}) begin
          fails++; $display("FAIL rnd_st_req[%0d]: got addr=%h we=%b strb=%b data=%h expected %h 1 %b %h", it, r_addr, r_we, r_strb, r_wdata, addr & 32'hFFFFFFFC, model_strb(op, addr), model_wdata(op, wd)); end
        tests++; if (!r_wb || r_wb_cyc != 2 + rdly || r_wb_en !== 1'b0 || !r_rdy) begin
          fails++; $display("FAIL rnd_st_wb[%0d]: got wb=%b cyc=%0d en=%b ready=%b expected 1 %0d 0 1", it, r_wb, r_wb_cyc, r_wb_en, r_rdy, 2 + rdly); end
      end else begin
        tests++; if ({r_got_req, r_addr, r_we, r_strb} !== {1'b1, addr & 32'hFFFFFFFC, 1'b0, 4'h0}) begin
          fails++; $display("FAIL rnd_ld_req[%0d]: got addr=%h we=%b strb=%b expected %h 0 0000", it, r_addr, r_we, r_strb, addr & 32'hFFFFFFFC); end
        tests++; if (!r_wb || r_wb_cyc != 3 + rdly + sdly || !r_rdy) begin
          fails++; $display("FAIL rnd_ld_lat[%0d]: got wb=%b cyc=%0d ready=%b expected 1 %0d 1", it, r_wb, r_wb_cyc, r_rdy, 3 + rdly + sdly); end
        tests++; if ({r_wb_en, r_wb_addr, r_wb_data} !== {(rd != 5'd0), rd, model_load(op, addr, rdata)}) begin
          fails++; $display("FAIL rnd_ld_wb[%0d]: got en=%b rd=%0d data=%h expected %b %0d %h", it, r_wb_en, r_wb_addr, r_wb_data, (rd != 5'd0), rd, model_load(op, addr, rdata)); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_aluop = '0; req_addr = '0;
    req_wdata = '0; req_rd = '0; req_pc = '0; dcache_req_ready = 1'b0;
    dcache_resp_valid = 1'b0; dcache_rdata = '0;
    req_valid1 = 1'b0; flush1 = 1'b0; dcache_req_ready1 = 1'b0;
    test_reset();
    test_load_word();
    test_load_ext();
    test_store_stall();
    test_ale();
    test_flush_wait();
    test_flush_req();
    test_reset_in_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
